// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-requester round-robin arbiter with a hold-time limit.
//
// A registered 2-bit owner index is decoded (2-to-4) into a registered
// one-hot grant. Priority rotates from the most recent owner. Under
// contention, an owner that keeps requesting is forced off after MAX_HOLD
// consecutive grant cycles.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles while someone else waits (0 = unlimited)
//   CNT_W     hold counter width; MAX_HOLD must be < 2**CNT_W
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   request per requester, held while the resource is wanted
//   gnt[3:0]   registered one-hot grant, zero when idle
//   gnt_idx    registered binary index of the current owner
//   gnt_valid  high while any grant is asserted
//   preempt    one-cycle pulse after an edge where the hold limit forced a handoff
//
// Handshake: a requester owns the resource in every cycle its gnt bit is
// high. It holds req high for as long as it wants the resource. Dropping
// req releases the resource at the next edge. A grant only ever changes on
// a rising clock edge.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam bit               HOLD_EN = (MAX_HOLD != 0);
    // Preempt once the owner has held for MAX_HOLD cycles. The counter starts
    // at 0 on the grant edge, so the limit is reached at MAX_HOLD-1.
    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nx;
    logic [1:0]       last, last_nx;
    logic [1:0]       idx_nx;
    logic [CNT_W-1:0] hold_cnt, cnt_nx;
    logic             valid_nx;
    logic             pre_nx;
    logic [3:0]       others;
    logic [2:0]       pick_all;
    logic [2:0]       pick_oth;

    // 2-to-4 decoder shared by the grant register and the owner mask.
    function automatic logic [3:0] decode(input logic [1:0] idx);
        logic [3:0] oh;
        oh      = 4'b0000;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // Scan base+1, base+2, base+3, base (mod 4). Returns {found, index}.
    // The loop runs backwards so the closest candidate is assigned last and wins.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] cand;
        logic [2:0] res;
        res = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            cand = base + 2'(k);
            if (r[cand]) res = {1'b1, cand};
        end
        return res;
    endfunction

    // In GRANT, last always equals gnt_idx. Masking the owner out of req
    // leaves only the competitors.
    assign others   = req & ~decode(gnt_idx);
    assign pick_all = pick(req, last);
    assign pick_oth = pick(others, last);

    always_comb begin
        state_nx = state;
        idx_nx   = gnt_idx;
        last_nx  = last;
        cnt_nx   = hold_cnt;
        valid_nx = gnt_valid;
        pre_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (pick_all[2]) begin
                    state_nx = GRANT;
                    idx_nx   = pick_all[1:0];
                    last_nx  = pick_all[1:0];
                    cnt_nx   = '0;
                    valid_nx = 1'b1;
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    // Release takes priority over a coincident preemption.
                    cnt_nx = '0;
                    if (pick_oth[2]) begin
                        idx_nx  = pick_oth[1:0];
                        last_nx = pick_oth[1:0];
                    end else begin
                        state_nx = IDLE;
                        valid_nx = 1'b0;
                    end
                end else if (HOLD_EN && (|others) && (hold_cnt >= LIMIT)) begin
                    // The comparison is >= and not == so that a competitor
                    // arriving after the limit has passed still forces a
                    // handoff on the next edge.
                    idx_nx  = pick_oth[1:0];
                    last_nx = pick_oth[1:0];
                    cnt_nx  = '0;
                    pre_nx  = 1'b1;
                end else if (hold_cnt != CNT_MAX) begin
                    cnt_nx = hold_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            gnt_idx   <= 2'b00;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
            hold_cnt  <= '0;
            last      <= 2'd3;
        end else begin
            state     <= state_nx;
            gnt       <= valid_nx ? decode(idx_nx) : 4'b0000;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
            preempt   <= pre_nx;
            hold_cnt  <= cnt_nx;
            last      <= last_nx;
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_q[$];

    rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    // Advance one edge and sample 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] eg, input logic ep);
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_valid"}, 32'(gnt_valid), 32'(|eg));
        if (eg != 4'b0000) check({tag, "_idx"}, 32'(gnt_idx), 32'(idx_of(eg)));
        check({tag, "_preempt"}, 32'(preempt), 32'(ep));
        check({tag, "_onehot0"}, 32'($onehot0(gnt)), 32'd1);
    endtask

    task automatic do_reset();
        req   = 4'b0000;
        rst_n = 1'b0;
        #3;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_idx", 32'(gnt_idx), 32'h0);
        check("rst_valid", 32'(gnt_valid), 32'h0);
        check("rst_preempt", 32'(preempt), 32'h0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] oh;
        logic [1:0] e;

        // basic grant, back-to-back handoff, release to idle
        do_reset();
        req = 4'b1010;
        step(); expect_out("t1_first", 4'b0010, 1'b0);
        req = 4'b1000;
        step(); expect_out("t1_handoff", 4'b1000, 1'b0);
        req = 4'b0000;
        step(); expect_out("t1_idle", 4'b0000, 1'b0);

        // full rotation, each owner drops after two cycles
        do_reset();
        exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
        exp_q.push_back(2'd3); exp_q.push_back(2'd0);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            e  = exp_q.pop_front();
            oh = 4'b0001 << e;
            step(); expect_out("t2_rot_a", oh, 1'b0);
            req = 4'b1111;
            step(); expect_out("t2_rot_b", oh, 1'b0);
            req = 4'b1111 & ~oh;
        end
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // hold limit alternation with 0101 held
        do_reset();
        req = 4'b0101;
        for (int r = 0; r < 4; r++) begin
            oh = r[0] ? 4'b0100 : 4'b0001;
            for (int c = 0; c < 8; c++) begin
                step();
                expect_out("t3_hold", oh, (r > 0 && c == 0) ? 1'b1 : 1'b0);
            end
        end

        // no contention: no preempt past the limit, then a late competitor
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            step(); expect_out("t4_solo", 4'b0100, 1'b0);
        end
        req = 4'b0101;
        step(); expect_out("t4_late", 4'b0001, 1'b1);
        step(); expect_out("t4_after", 4'b0001, 1'b0);

        // asynchronous reset mid-grant
        do_reset();
        req = 4'b1000;
        step(); expect_out("t5_own3", 4'b1000, 1'b0);
        step(); expect_out("t5_own3b", 4'b1000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_gnt", 32'(gnt), 32'h0);
        check("t5_async_valid", 32'(gnt_valid), 32'h0);
        check("t5_async_idx", 32'(gnt_idx), 32'h0);
        step();
        req   = 4'b1001;
        rst_n = 1'b1;
        step(); expect_out("t5_first0", 4'b0001, 1'b0);

        // release coinciding with the preemption edge
        do_reset();
        req = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            step(); expect_out("t6_hold", 4'b0001, 1'b0);
        end
        req = 4'b0100;
        step(); expect_out("t6_release", 4'b0100, 1'b0);
        step(); expect_out("t6_after", 4'b0100, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
